// File: rtl/axis_fp16_pack_128_if.sv
// AXI-Stream bundle for the FP16 width packer. W sets the tdata width.
// When AXIS_PACK_TKEEP_EN is defined, the bundle also carries byte enables (tkeep).
interface axis_fp16_pack_128_if #(
  parameter int unsigned W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
`ifdef AXIS_PACK_TKEEP_EN
  logic [W/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/axis_fp16_pack_128.sv
// Packs IN_W-bit FP16 AXI-Stream beats into 128-bit beats of 8 lanes and zero-pads short packets.
// Defining AXIS_PACK_TKEEP_EN adds a registered m.tkeep output.
module axis_fp16_pack_128 #(
  parameter int unsigned IN_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_fp16_pack_128_if.slave   s,
  axis_fp16_pack_128_if.master  m
);
  localparam int unsigned R  = 128 / IN_W;
  localparam int unsigned L  = IN_W / 16;
  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;

  logic [127:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          acc_last_q, acc_last_d;
  logic [127:0]  m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
`ifdef AXIS_PACK_TKEEP_EN
  logic [15:0]   acc_keep_q, acc_keep_d;
  logic [15:0]   m_keep_q, m_keep_d;
`endif

  logic oslot_free;
  logic s_ready;
  logic accept;
  logic xfer;

  // s_ready depends only on registered state and m.tready.
  assign oslot_free = !m_valid_q || m.tready;
  assign s_ready    = !full_q || oslot_free;
  assign accept     = s.tvalid && s_ready;
  assign xfer       = full_q && oslot_free;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    acc_last_d = acc_last_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
`ifdef AXIS_PACK_TKEEP_EN
    acc_keep_d = acc_keep_q;
    m_keep_d   = m_keep_q;
`endif

    if (xfer) begin
      m_data_d  = acc_q;
      m_last_d  = acc_last_q;
      m_valid_d = 1'b1;
      full_d    = 1'b0;
`ifdef AXIS_PACK_TKEEP_EN
      m_keep_d  = acc_keep_q;
`endif
    end else if (m.tready) begin
      m_valid_d = 1'b0;
    end

    // The output register takes the old acc contents above; on the same edge, a new beat starts a fresh acc.
    if (accept) begin
      if (cnt_q == '0) acc_d = '0;
      for (int unsigned i = 0; i < R; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i*IN_W +: IN_W] = s.tdata;
`ifdef AXIS_PACK_TKEEP_EN
          acc_keep_d = 16'((32'd1 << (2 * L * (i + 1))) - 32'd1);
`endif
        end
      end
      if ((cnt_q == CW'(R - 1)) || s.tlast) begin
        full_d     = 1'b1;
        acc_last_d = s.tlast;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      acc_last_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
`ifdef AXIS_PACK_TKEEP_EN
      acc_keep_q <= '0;
      m_keep_q   <= '0;
`endif
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      acc_last_q <= acc_last_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
`ifdef AXIS_PACK_TKEEP_EN
      acc_keep_q <= acc_keep_d;
      m_keep_q   <= m_keep_d;
`endif
    end
  end

  assign s.tready = s_ready;
  assign m.tdata  = m_data_q;
  assign m.tvalid = m_valid_q;
  assign m.tlast  = m_last_q;
`ifdef AXIS_PACK_TKEEP_EN
  assign m.tkeep  = m_keep_q;
`endif

endmodule

// File: tb/tb_axis_fp16_pack_128.sv
// Directed bench for axis_fp16_pack_128 at IN_W=32, 16 and 64.
// The tkeep checks are compiled in when AXIS_PACK_TKEEP_EN is defined.
module tb_axis_fp16_pack_128;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_fp16_pack_128_if #(.W(32))  s32 ();
  axis_fp16_pack_128_if #(.W(128)) m32 ();
  axis_fp16_pack_128_if #(.W(16))  s16 ();
  axis_fp16_pack_128_if #(.W(128)) m16 ();
  axis_fp16_pack_128_if #(.W(64))  s64 ();
  axis_fp16_pack_128_if #(.W(128)) m64 ();

  axis_fp16_pack_128 #(.IN_W(32)) u32 (.aclk(aclk), .aresetn(aresetn), .s(s32), .m(m32));
  axis_fp16_pack_128 #(.IN_W(16)) u16 (.aclk(aclk), .aresetn(aresetn), .s(s16), .m(m16));
  axis_fp16_pack_128 #(.IN_W(64)) u64 (.aclk(aclk), .aresetn(aresetn), .s(s64), .m(m64));

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic rdy_dir = 1'b1;
  logic rdy_rnd = 1'b1;
  logic rnd_en  = 1'b0;
  logic mon_en  = 1'b0;
  logic [128:0] obs_q[$];
  logic [128:0] exp_q[$];

  assign m32.tready = rnd_en ? rdy_rnd : rdy_dir;

  always @(negedge aclk) rdy_rnd = 1'($urandom_range(0, 1));

  // Capture late in the low phase, when inputs have settled ahead of the next rising edge.
  always begin
    @(negedge aclk);
    #4;
    if (mon_en && m32.tvalid && m32.tready) obs_q.push_back({m32.tlast, m32.tdata});
    if (mon_en && m32.tready) begin
      tests++;
      assert (s32.tready === 1'b1) else begin
        fails++;
        $error("FAIL stream_s_tready obs=%b exp=1", s32.tready);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send32(input logic [31:0] d, input logic last);
    int unsigned n = 0;
    s32.tdata = d; s32.tvalid = 1'b1; s32.tlast = last;
    #1;
    while (!s32.tready && n < 100) begin @(negedge aclk); #1; n++; end
    chk("send32_ready", {127'd0, s32.tready}, 128'd1);
    @(posedge aclk);
    @(negedge aclk);
    s32.tvalid = 1'b0; s32.tlast = 1'b0;
  endtask

  task automatic send16(input logic [15:0] d, input logic last);
    int unsigned n = 0;
    s16.tdata = d; s16.tvalid = 1'b1; s16.tlast = last;
    #1;
    while (!s16.tready && n < 100) begin @(negedge aclk); #1; n++; end
    chk("send16_ready", {127'd0, s16.tready}, 128'd1);
    @(posedge aclk);
    @(negedge aclk);
    s16.tvalid = 1'b0; s16.tlast = 1'b0;
  endtask

  task automatic send64(input logic [63:0] d, input logic last);
    int unsigned n = 0;
    s64.tdata = d; s64.tvalid = 1'b1; s64.tlast = last;
    #1;
    while (!s64.tready && n < 100) begin @(negedge aclk); #1; n++; end
    chk("send64_ready", {127'd0, s64.tready}, 128'd1);
    @(posedge aclk);
    @(negedge aclk);
    s64.tvalid = 1'b0; s64.tlast = 1'b0;
  endtask

  initial begin
    logic [127:0] word;
    logic [31:0]  d;
    int unsigned  n;

    s32.tvalid = 1'b0; s32.tlast = 1'b0; s32.tdata = '0;
    s16.tvalid = 1'b0; s16.tlast = 1'b0; s16.tdata = '0;
    s64.tvalid = 1'b0; s64.tlast = 1'b0; s64.tdata = '0;
    m16.tready = 1'b1; m64.tready = 1'b1;
`ifdef AXIS_PACK_TKEEP_EN
    s32.tkeep = '1; s16.tkeep = '1; s64.tkeep = '1;
`endif

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_tdata",  m32.tdata, 128'd0);
    chk("rst_tvalid", {127'd0, m32.tvalid}, 128'd0);
    chk("rst_tlast",  {127'd0, m32.tlast}, 128'd0);
`ifdef AXIS_PACK_TKEEP_EN
    chk("rst_tkeep",  {112'd0, m32.tkeep}, 128'd0);
`endif
    aresetn = 1'b1;
    #1;
    chk("rst_s_tready", {127'd0, s32.tready}, 128'd1);
    @(negedge aclk);

    // Full beat, IN_W=32, with one cycle of latency
    send32(32'h3C003C00, 1'b0);
    send32(32'h40004000, 1'b0);
    send32(32'h42004200, 1'b0);
    send32(32'h44004400, 1'b1);
    chk("full_lat_valid0", {127'd0, m32.tvalid}, 128'd0);
    @(negedge aclk);
    chk("full_valid", {127'd0, m32.tvalid}, 128'd1);
    chk("full_data",  m32.tdata, 128'h44004400_42004200_40004000_3C003C00);
    chk("full_last",  {127'd0, m32.tlast}, 128'd1);
`ifdef AXIS_PACK_TKEEP_EN
    chk("full_keep",  {112'd0, m32.tkeep}, 128'h0000FFFF);
`endif
    @(negedge aclk);
    chk("full_valid_drop", {127'd0, m32.tvalid}, 128'd0);

    // Short packet
    send32(32'h11112222, 1'b0);
    send32(32'h33334444, 1'b1);
    @(negedge aclk);
    chk("short_valid", {127'd0, m32.tvalid}, 128'd1);
    chk("short_data",  m32.tdata, 128'h00000000_00000000_33334444_11112222);
    chk("short_last",  {127'd0, m32.tlast}, 128'd1);
`ifdef AXIS_PACK_TKEEP_EN
    chk("short_keep",  {112'd0, m32.tkeep}, 128'h000000FF);
`endif
    @(negedge aclk);

    // Backpressure: two output beats worth of input with the sink stalled
    rdy_dir = 1'b0;
    for (int i = 0; i < 4; i++) send32(32'hA0000000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) send32(32'hB0000000 + 32'(i), 1'b0);
    #1;
    chk("bp_s_tready0", {127'd0, s32.tready}, 128'd0);
    chk("bp_valid",     {127'd0, m32.tvalid}, 128'd1);
    chk("bp_data_a",    m32.tdata, 128'hA0000003_A0000002_A0000001_A0000000);
    chk("bp_last_a",    {127'd0, m32.tlast}, 128'd0);
    repeat (3) @(negedge aclk);
    chk("bp_hold_a",    m32.tdata, 128'hA0000003_A0000002_A0000001_A0000000);
    chk("bp_hold_valid", {127'd0, m32.tvalid}, 128'd1);
    rdy_dir = 1'b1;
    @(negedge aclk);
    chk("bp_valid_b",   {127'd0, m32.tvalid}, 128'd1);
    chk("bp_data_b",    m32.tdata, 128'hB0000003_B0000002_B0000001_B0000000);
    chk("bp_last_b",    {127'd0, m32.tlast}, 128'd0);
    #1;
    chk("bp_s_tready1", {127'd0, s32.tready}, 128'd1);
    @(negedge aclk);
    chk("bp_drained",   {127'd0, m32.tvalid}, 128'd0);

    // Streaming: 8 packets of 8 random beats, random sink readiness
    mon_en = 1'b1;
    rnd_en = 1'b1;
    word = '0;
    for (int p = 0; p < 8; p++) begin
      for (int b = 0; b < 8; b++) begin
        d = $urandom;
        if (b % 4 == 0) word = '0;
        word[(b % 4) * 32 +: 32] = d;
        if (b % 4 == 3) exp_q.push_back({(b == 7), word});
        send32(d, (b == 7));
      end
    end
    rnd_en = 1'b0;
    n = 0;
    while (obs_q.size() < 16 && n < 500) begin @(negedge aclk); n++; end
    mon_en = 1'b0;
    chk("stream_count", 128'(obs_q.size()), 128'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < obs_q.size()) begin
        chk("stream_data", obs_q[i][127:0], exp_q[i][127:0]);
        chk("stream_last", {127'd0, obs_q[i][128]}, {127'd0, exp_q[i][128]});
      end
    end
    @(negedge aclk);

    // Reset in the middle of a packet
    send32(32'hAAAA0001, 1'b0);
    send32(32'hAAAA0002, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("mrst_tdata",  m32.tdata, 128'd0);
    chk("mrst_tvalid", {127'd0, m32.tvalid}, 128'd0);
    chk("mrst_tlast",  {127'd0, m32.tlast}, 128'd0);
    chk("mrst_ready",  {127'd0, s32.tready}, 128'd1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mrst_no_beat", {127'd0, m32.tvalid}, 128'd0);
    chk("mrst_ready2",  {127'd0, s32.tready}, 128'd1);
    send32(32'h00020001, 1'b0);
    send32(32'h00040003, 1'b0);
    chk("mrst_no_early", {127'd0, m32.tvalid}, 128'd0);
    send32(32'h00060005, 1'b0);
    send32(32'h00080007, 1'b1);
    @(negedge aclk);
    chk("mrst_valid", {127'd0, m32.tvalid}, 128'd1);
    chk("mrst_data",  m32.tdata, 128'h00080007_00060005_00040003_00020001);
    chk("mrst_last",  {127'd0, m32.tlast}, 128'd1);
    @(negedge aclk);

    // IN_W=16: eight beats per output, lane 0 first
    send16(16'h3C00, 1'b0);
    for (int i = 1; i < 8; i++) send16(16'(i), (i == 7));
    @(negedge aclk);
    chk("w16_valid", {127'd0, m16.tvalid}, 128'd1);
    chk("w16_data",  m16.tdata, 128'h0007_0006_0005_0004_0003_0002_0001_3C00);
    chk("w16_lane0", {112'd0, m16.tdata[15:0]}, 128'h3C00);
    chk("w16_last",  {127'd0, m16.tlast}, 128'd1);
    @(negedge aclk);
    send16(16'hAAAA, 1'b0);
    send16(16'hBBBB, 1'b0);
    send16(16'hCCCC, 1'b1);
    @(negedge aclk);
    chk("w16_short", m16.tdata, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    chk("w16_short_last", {127'd0, m16.tlast}, 128'd1);
`ifdef AXIS_PACK_TKEEP_EN
    chk("w16_short_keep", {112'd0, m16.tkeep}, 128'h003F);
`endif
    @(negedge aclk);

    // IN_W=64: two beats per output; slot R-1 without tlast, then tlast held high
    send64(64'h0003_0002_0001_3C00, 1'b0);
    send64(64'h0007_0006_0005_0004, 1'b0);
    @(negedge aclk);
    chk("w64_valid", {127'd0, m64.tvalid}, 128'd1);
    chk("w64_data",  m64.tdata, 128'h0007_0006_0005_0004_0003_0002_0001_3C00);
    chk("w64_last0", {127'd0, m64.tlast}, 128'd0);
    @(negedge aclk);
    send64(64'h1111_2222_3333_4444, 1'b1);
    @(negedge aclk);
    chk("w64_single", m64.tdata, 128'h0000_0000_0000_0000_1111_2222_3333_4444);
    chk("w64_single_last", {127'd0, m64.tlast}, 128'd1);
`ifdef AXIS_PACK_TKEEP_EN
    chk("w64_single_keep", {112'd0, m64.tkeep}, 128'h00FF);
`endif
    @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_fp16_pack_128.md
# axis_fp16_pack_128

Upstream width-packing stage for the FP16×8 compute stages. It takes a narrow AXI-Stream of FP16 lanes from the DMA MM2S port (IN_W bits per beat) and assembles 128-bit beats of 8 FP16 lanes. Its output connects directly to the 128-bit `s_*` port of the per-lane FP16 arithmetic stage. It handles short packets by zero-padding and fully decouples backpressure with an assembly register plus an output register.

## Interface
- `IN_W`, default 32: input width in bits. Legal values: 16, 32, 64. Lanes per input beat L = IN_W/16. Beats per output beat R = 128/IN_W.
- `aclk`  in  1: clock; all logic on rising edge.
- `aresetn`  in  1: reset, asynchronous, active-low.
- `s_tdata`  in  IN_W: input FP16 lanes, lane 0 at bits [15:0].
- `s_tvalid`  in  1: input valid.
- `s_tready`  out  1: input ready.
- `s_tlast`  in  1: last input beat of the packet.
- `m_tdata`  out  128: packed 8×FP16.
- `m_tvalid`  out  1: output valid.
- `m_tready`  in  1: downstream ready.
- `m_tlast`  out  1: last output beat of the packet.
- `m_tkeep`  out  16: byte enables. Present only with `AXIS_PACK_TKEEP_EN`.

## Operation
- State:
  - `acc[127:0]`: assembly register.
  - `cnt` (0..R-1): input slot index.
  - `full`: acc complete, awaiting transfer.
  - `acc_last`: tlast flag for acc.
  - Output register holding `m_tdata`, `m_tlast` and `m_tkeep`.
- Input accept (`s_tvalid && s_tready`):
  - Write `s_tdata` into `acc[cnt*IN_W +: IN_W]`.
  - If cnt is 0, first clear all other slots of acc to 16'h0000 (+0.0).
  - If `cnt==R-1 || s_tlast`: set `full`, set `acc_last=s_tlast`, set cnt to 0.
  - Otherwise cnt increments by 1.
- Slot free: `oslot_free = !m_tvalid || m_tready`.
- Transfer: when `full && oslot_free`, the output register loads acc and acc_last, `m_tvalid` is set to 1, and `full` is cleared.
- When `!full && m_tready`, `m_tvalid` is cleared.
- `s_tready = !full || oslot_free`. While acc is being transferred, a new beat is accepted into slot 0 on the same edge.
- Short packet: `s_tlast` at cnt=k<R-1 emits one output beat.
  - Slots 0..k carry data; slots k+1..R-1 are zero.
  - `m_tlast=1`.
- A beat at slot R-1 without `s_tlast` emits `m_tlast=0`. Packets spanning several output beats keep tlast only on their final beat.
- No arithmetic; data is bit-exact, with no NaN or denormal handling.
- Reset (any time):
  - acc, cnt, `full` and `acc_last` are cleared to 0.
  - `m_tdata=0`, `m_tvalid=0`, `m_tlast=0`, `m_tkeep=0`.
  - `s_tready` is 1 after reset deassertion.
  - A partial packet in progress is discarded and no beat is emitted.

## Timing
- Latency: the completing input beat is accepted at edge N, `full` is set at N, and `m_tvalid` rises at edge N+1. Input-complete to output is 1 cycle.
- Throughput: 1 input beat per cycle sustained with `m_tready=1`. This gives 1 output beat every R cycles (every cycle when IN_W is 64 and `s_tlast` is held high).
- Backpressure:
  - `m_tready=0` with `m_tvalid=1` and `full=1` forces `s_tready=0`.
  - With `m_tready=0` and `full=0`, the next packet keeps filling acc.
- `m_tdata`, `m_tlast` and `m_tkeep` remain stable while `m_tvalid && !m_tready`.
- `s_tready` depends only on registered state plus `m_tready`; there is no path from `s_tvalid` to `s_tready`.

## Configuration
- `AXIS_PACK_TKEEP_EN` defined:
  - The `m_tkeep[15:0]` port exists.
  - Bits [2*L*(k+1)-1:0] are set for a beat filled through slot k, and all higher bits are 0.
  - A full beat gives 16'hFFFF.
  - `m_tkeep` is registered alongside `m_tdata`.
- Not defined: no `m_tkeep` port. Downstream sees zero-padded lanes only.

## Test plan
- **Full beat, IN_W=32:** beats 0x3C003C00, 0x40004000, 0x42004200, 0x44004400 with tlast on the 4th, `m_tready=1` → one output `m_tdata=128'h44004400_42004200_40004000_3C003C00`, `m_tlast=1`, one cycle after the 4th accept.
- **Short packet:** 2 beats 0x11112222, 0x33334444 with tlast on the 2nd → `m_tdata=128'h0_0_33334444_11112222`, `m_tlast=1`, `m_tkeep=16'h00FF` (when enabled).
- **Backpressure:**
  - Hold `m_tready=0`; stream 8 beats without tlast.
  - The 1st output beat is held stable.
  - The 2nd set of 4 beats fills acc, then `s_tready=0`.
  - Release `m_tready` → both beats are emitted in order and no data is lost.
- **Streaming:** 64 random beats, tlast every 8, `m_tready` toggled randomly → scoreboard matches. Sustained `s_tready=1` whenever `m_tready=1`.
- **Reset mid-packet:** assert aresetn low after 2 of 4 beats → all outputs are 0 and `s_tready=1` after release. The next 4-beat packet is emitted alone, with no stale lanes.
- **IN_W=16 and IN_W=64:** 8 and 2 beats per output beat respectively → correct lane order. 16'h3C00 in input beat 0 appears at `m_tdata[15:0]`.
